// File: rtl/icache_ifill_unit.sv
// Instruction-cache line refill engine: one line-aligned read, four beats
// assembled into a line, with kill/drain and sticky bus-error reporting.
module icache_ifill_unit #(
    parameter int PADDR_SIZE = 26,
    parameter int LINE_WIDTH = 128,
    parameter int BEAT_WIDTH = 32,
    parameter int N_BEATS    = 4,
    parameter int WAY_BITS   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    input  logic [WAY_BITS-1:0]   req_way_i,
    input  logic [PADDR_SIZE-1:0] req_paddr_i,
    output logic                  req_ready_o,
    input  logic                  kill_i,
    output logic                  mem_req_valid_o,
    output logic [PADDR_SIZE-1:0] mem_req_addr_o,
    input  logic                  mem_req_ready_i,
    input  logic                  mem_resp_valid_i,
    input  logic [1:0]            mem_resp_beat_i,
    input  logic [BEAT_WIDTH-1:0] mem_resp_data_i,
    input  logic                  mem_resp_err_i,
    output logic                  fill_valid_o,
    output logic [WAY_BITS-1:0]   fill_way_o,
    output logic [PADDR_SIZE-1:0] fill_paddr_o,
    output logic [LINE_WIDTH-1:0] fill_data_o,
    output logic                  fill_xcpt_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(N_BEATS);
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_COLLECT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state, w_state;
    logic [CNT_W-1:0]      r_cnt, w_cnt;
    logic                  r_err, w_err;
    logic [LINE_WIDTH-1:0] r_line, w_line;
    logic [WAY_BITS-1:0]   r_way, w_way;
    logic [PADDR_SIZE-1:0] r_paddr, w_paddr;
    logic                  w_last;

    // The final beat is decided by how many beats arrived, not by their index.
    assign w_last = (r_cnt == CNT_W'(N_BEATS - 1));

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_err   = r_err;
        w_line  = r_line;
        w_way   = r_way;
        w_paddr = r_paddr;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_way   = req_way_i;
                    w_paddr = {req_paddr_i[PADDR_SIZE-1:OFF_W], OFF_W'(0)};
                    w_line  = '0;
                    w_cnt   = '0;
                    w_err   = 1'b0;
                    w_state = S_SEND;
                end
            end
            S_SEND: begin
                if (mem_req_ready_i)
                    w_state = kill_i ? S_DRAIN : S_COLLECT;
                else if (kill_i)
                    w_state = S_IDLE;
            end
            S_COLLECT: begin
                if (mem_resp_valid_i) begin
                    w_cnt = r_cnt + CNT_W'(1);
                    if (!kill_i) begin
                        for (int i = 0; i < N_BEATS; i++)
                            if (mem_resp_beat_i == 2'(i))
                                w_line[i*BEAT_WIDTH +: BEAT_WIDTH] = mem_resp_data_i;
                        w_err = r_err | mem_resp_err_i
                              | (mem_resp_beat_i != 2'(r_cnt));
                    end
                end
                if (kill_i)
                    w_state = (mem_resp_valid_i && w_last) ? S_IDLE : S_DRAIN;
                else if (mem_resp_valid_i && w_last)
                    w_state = S_DONE;
            end
            S_DRAIN: begin
                if (mem_resp_valid_i) begin
                    w_cnt = r_cnt + CNT_W'(1);
                    if (w_last)
                        w_state = S_IDLE;
                end
            end
            S_DONE: w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_line  <= '0;
            r_way   <= '0;
            r_paddr <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_err   <= w_err;
            r_line  <= w_line;
            r_way   <= w_way;
            r_paddr <= w_paddr;
        end
    end

    assign req_ready_o     = (r_state == S_IDLE);
    assign busy_o          = (r_state != S_IDLE);
    assign mem_req_valid_o = (r_state == S_SEND);
    assign mem_req_addr_o  = r_paddr;
    assign fill_valid_o    = (r_state == S_DONE);
    assign fill_xcpt_o     = r_err;
    assign fill_way_o      = r_way;
    assign fill_paddr_o    = r_paddr;
    assign fill_data_o     = r_line;

endmodule

// File: tb/tb_icache_ifill_unit.sv
// Bench for icache_ifill_unit: directed test-plan scenarios then random
// traffic, all checked every cycle against a transaction-level model.
module tb_icache_ifill_unit;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         req_valid_i;
    logic [1:0]   req_way_i;
    logic [25:0]  req_paddr_i;
    logic         req_ready_o;
    logic         kill_i;
    logic         mem_req_valid_o;
    logic [25:0]  mem_req_addr_o;
    logic         mem_req_ready_i;
    logic         mem_resp_valid_i;
    logic [1:0]   mem_resp_beat_i;
    logic [31:0]  mem_resp_data_i;
    logic         mem_resp_err_i;
    logic         fill_valid_o;
    logic [1:0]   fill_way_o;
    logic [25:0]  fill_paddr_o;
    logic [127:0] fill_data_o;
    logic         fill_xcpt_o;
    logic         busy_o;

    int errors = 0;
    int checks = 0;

    icache_ifill_unit dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_way_i       (req_way_i),
        .req_paddr_i     (req_paddr_i),
        .req_ready_o     (req_ready_o),
        .kill_i          (kill_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_resp_valid_i(mem_resp_valid_i),
        .mem_resp_beat_i (mem_resp_beat_i),
        .mem_resp_data_i (mem_resp_data_i),
        .mem_resp_err_i  (mem_resp_err_i),
        .fill_valid_o    (fill_valid_o),
        .fill_way_o      (fill_way_o),
        .fill_paddr_o    (fill_paddr_o),
        .fill_data_o     (fill_data_o),
        .fill_xcpt_o     (fill_xcpt_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    // Model: which phase of a fill we are in and how many beats were seen.
    localparam int IDLE = 0, SEND = 1, COLL = 2, DRN = 3, DONE = 4;
    int          m_ph;
    int          m_n;
    bit          m_err;
    bit          m_rst;
    logic [31:0] m_words [4];
    logic [1:0]  m_way;
    logic [25:0] m_addr;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit last;
        if (rst_i) begin
            m_ph = IDLE; m_n = 0; m_err = 0; m_way = 0; m_addr = 0;
            for (int i = 0; i < 4; i++) m_words[i] = 0;
            m_rst = 1;
            return;
        end
        m_rst = 0;
        last = (m_n == 3);
        case (m_ph)
            IDLE: if (req_valid_i) begin
                m_way  = req_way_i;
                m_addr = req_paddr_i & ~26'hF;
                for (int i = 0; i < 4; i++) m_words[i] = 0;
                m_n = 0; m_err = 0; m_ph = SEND;
            end
            SEND: begin
                if (mem_req_ready_i) m_ph = kill_i ? DRN : COLL;
                else if (kill_i) m_ph = IDLE;
            end
            COLL: begin
                if (mem_resp_valid_i) begin
                    if (!kill_i) begin
                        m_words[mem_resp_beat_i] = mem_resp_data_i;
                        if (mem_resp_err_i || mem_resp_beat_i != 2'(m_n))
                            m_err = 1;
                    end
                    m_n++;
                end
                if (kill_i) m_ph = (mem_resp_valid_i && last) ? IDLE : DRN;
                else if (mem_resp_valid_i && last) m_ph = DONE;
            end
            DRN: if (mem_resp_valid_i) begin
                m_n++;
                if (m_n == 4) m_ph = IDLE;
            end
            default: m_ph = IDLE;
        endcase
    endtask

    task automatic compare();
        chk("req_ready", 128'(req_ready_o), 128'(m_ph == IDLE));
        chk("busy", 128'(busy_o), 128'(m_ph != IDLE));
        chk("mem_req_valid", 128'(mem_req_valid_o), 128'(m_ph == SEND));
        chk("fill_valid", 128'(fill_valid_o), 128'(m_ph == DONE));
        if (m_ph == SEND)
            chk("mem_req_addr", 128'(mem_req_addr_o), 128'(m_addr));
        if (m_ph == DONE) begin
            chk("fill_data", fill_data_o,
                {m_words[3], m_words[2], m_words[1], m_words[0]});
            chk("fill_way", 128'(fill_way_o), 128'(m_way));
            chk("fill_paddr", 128'(fill_paddr_o), 128'(m_addr));
            chk("fill_xcpt", 128'(fill_xcpt_o), 128'(m_err));
        end
        if (m_rst) begin
            chk("rst_data", fill_data_o, 128'h0);
            chk("rst_addr", 128'(mem_req_addr_o), 128'h0);
            chk("rst_way", 128'(fill_way_o), 128'h0);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic clr();
        rst_i = 0; kill_i = 0; mem_req_ready_i = 0;
        mem_resp_valid_i = 0; mem_resp_beat_i = 0;
        mem_resp_data_i = 0; mem_resp_err_i = 0;
    endtask

    task automatic send_req(input logic [1:0] w, input logic [25:0] pa);
        req_valid_i = 1; req_way_i = w; req_paddr_i = pa;
        tick();
        req_valid_i = 0;
    endtask

    task automatic accept_mem();
        mem_req_ready_i = 1;
        tick();
        mem_req_ready_i = 0;
    endtask

    task automatic beat(input logic [1:0] b, input logic [31:0] d,
                        input logic e);
        mem_resp_valid_i = 1; mem_resp_beat_i = b;
        mem_resp_data_i = d; mem_resp_err_i = e;
        tick();
        mem_resp_valid_i = 0; mem_resp_err_i = 0;
    endtask

    task automatic fill(input logic [1:0] w, input logic [25:0] pa,
                        input logic [31:0] base, input int err_beat);
        send_req(w, pa);
        accept_mem();
        for (int i = 0; i < 4; i++)
            beat(2'(i), base + 32'(i), i == err_beat);
    endtask

    initial begin
        bit acc;
        req_valid_i = 0; req_way_i = 0; req_paddr_i = 0;
        clr();
        rst_i = 1;
        tick();
        tick();
        rst_i = 0;
        chk("reset_ready", 128'(req_ready_o), 128'h1);

        // Basic fill
        send_req(2'd2, 26'h12345F);
        chk("basic_addr", 128'(mem_req_addr_o), 128'h123450);
        accept_mem();
        beat(0, 32'h11111111, 0);
        beat(1, 32'h22222222, 0);
        beat(2, 32'h33333333, 0);
        beat(3, 32'h44444444, 0);
        chk("basic_valid", 128'(fill_valid_o), 128'h1);
        chk("basic_data", fill_data_o,
            128'h44444444_33333333_22222222_11111111);
        chk("basic_way", 128'(fill_way_o), 128'h2);
        chk("basic_xcpt", 128'(fill_xcpt_o), 128'h0);
        tick();

        // Gapped beats with a second request held throughout
        req_valid_i = 1; req_way_i = 1; req_paddr_i = 26'h2000A4;
        tick();
        req_way_i = 3; req_paddr_i = 26'h3FFFFF7;
        accept_mem();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin tick(); tick(); end
            beat(2'(i), 32'hA0A00000 + 32'(i), 0);
        end
        chk("gap_data", fill_data_o,
            128'hA0A00003_A0A00002_A0A00001_A0A00000);
        chk("gap_ready_done", 128'(req_ready_o), 128'h0);
        tick();
        chk("b2b_ready", 128'(req_ready_o), 128'h1);
        tick();
        req_valid_i = 0;
        chk("b2b_addr", 128'(mem_req_addr_o), 128'h3FFFFF0);
        accept_mem();
        for (int i = 0; i < 4; i++) beat(2'(i), 32'($urandom), 0);
        tick();

        // Kill in SEND without ready
        send_req(0, 26'h100);
        kill_i = 1; tick(); kill_i = 0;
        chk("kill_send_valid", 128'(mem_req_valid_o), 128'h0);

        // Kill together with ready: drain 4 beats
        send_req(1, 26'h200);
        kill_i = 1; mem_req_ready_i = 1; tick(); clr();
        for (int i = 0; i < 4; i++) beat(2'(i), 32'hBAD0 + 32'(i), 0);
        chk("drain_busy", 128'(busy_o), 128'h0);

        // Kill after two beats, then a clean fill
        send_req(2, 26'h300);
        accept_mem();
        beat(0, 32'hDEAD0000, 0);
        beat(1, 32'hDEAD0001, 0);
        kill_i = 1; tick(); kill_i = 0;
        beat(2, 32'hDEAD0002, 0);
        beat(3, 32'hDEAD0003, 0);
        chk("kill2_busy", 128'(busy_o), 128'h0);
        fill(3, 26'h400, 32'h55550000, -1);
        chk("fresh_data", fill_data_o,
            128'h55550003_55550002_55550001_55550000);

        // Errors
        tick();
        fill(1, 26'h500, 32'h66660000, 1);
        chk("err_xcpt", 128'(fill_xcpt_o), 128'h1);
        tick();
        send_req(0, 26'h600);
        accept_mem();
        beat(1, 32'h77770000, 0);
        beat(0, 32'h77770001, 0);
        beat(2, 32'h77770002, 0);
        beat(3, 32'h77770003, 0);
        chk("ooo_xcpt", 128'(fill_xcpt_o), 128'h1);
        chk("ooo_data", fill_data_o,
            128'h77770003_77770002_77770000_77770001);
        tick();
        fill(2, 26'h700, 32'h88880000, -1);
        chk("clean_xcpt", 128'(fill_xcpt_o), 128'h0);
        tick();

        // Reset mid-COLLECT
        send_req(3, 26'h800);
        accept_mem();
        beat(0, 32'h99990000, 0);
        rst_i = 1; tick(); rst_i = 0;
        chk("rst_mid_data", fill_data_o, 128'h0);
        chk("rst_mid_ready", 128'(req_ready_o), 128'h1);
        fill(1, 26'h90C, 32'hAAAA0000, -1);
        chk("post_rst_data", fill_data_o,
            128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000);
        tick();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            rst_i = ($urandom % 300) == 0;
            if (!req_valid_i && ($urandom % 3) == 0) begin
                req_valid_i = 1;
                req_way_i = 2'($urandom);
                req_paddr_i = 26'($urandom);
            end
            kill_i = ($urandom % 12) == 0;
            mem_req_ready_i = 1'($urandom);
            mem_resp_valid_i = 1'($urandom);
            mem_resp_beat_i = (($urandom % 8) == 0) ? 2'($urandom)
                                                    : 2'(m_n);
            mem_resp_data_i = $urandom;
            mem_resp_err_i = ($urandom % 16) == 0;
            acc = (m_ph == IDLE) && req_valid_i && !rst_i;
            tick();
            if (acc) req_valid_i = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_ifill_unit.md
Name: icache_ifill_unit

Overview:
- Refill engine directly downstream of the L1 instruction-cache controller.
- Accepts one line-fill request (way, physical address) and issues a single line-aligned read to the memory side.
- Collects four 32-bit beats into a 128-bit line and returns the complete line to the icache for the selected way.
- Supports kill (abort with drain of in-flight beats) and error reporting.

Parameters:
- PADDR_SIZE, 26, physical address width.
- LINE_WIDTH, 128, cache line width in bits (equals WAY_WIDHT).
- BEAT_WIDTH, 32, memory response data width per beat.
- N_BEATS, 4, beats per line (LINE_WIDTH/BEAT_WIDTH); beat index width is $clog2(N_BEATS) = 2.
- WAY_BITS, 2, way index width ($clog2 of 4 ways).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  fill request from the icache.
- req_way_i  in  WAY_BITS  way to replace.
- req_paddr_i  in  PADDR_SIZE  miss physical address.
- req_ready_o  out  1  unit can accept a request.
- kill_i  in  1  abort the current fill.
- mem_req_valid_o  out  1  memory read request.
- mem_req_addr_o  out  PADDR_SIZE  line-aligned address; bits [3:0] are zero.
- mem_req_ready_i  in  1  memory accepted the request.
- mem_resp_valid_i  in  1  response beat valid.
- mem_resp_beat_i  in  2  beat index.
- mem_resp_data_i  in  BEAT_WIDTH  beat data.
- mem_resp_err_i  in  1  bus error on this beat.
- fill_valid_o  out  1  one-cycle pulse: line complete.
- fill_way_o  out  WAY_BITS  latched way.
- fill_paddr_o  out  PADDR_SIZE  latched line address.
- fill_data_o  out  LINE_WIDTH  assembled line.
- fill_xcpt_o  out  1  error seen during this fill; qualified by fill_valid_o.
- busy_o  out  1  state is not IDLE.

Behaviour:
- Clock and reset: single clock clk_i; synchronous active-high reset rst_i.
- Reset values:
  - State is IDLE; beat counter = 0; err flag = 0.
  - fill_data_o, fill_way_o, fill_paddr_o, mem_req_addr_o = 0.
  - All valid outputs = 0; busy_o = 0; req_ready_o = 1 after reset.
  - Reset mid-fill drops everything; no fill pulse is produced.
- FSM states: IDLE, SEND, COLLECT, DRAIN, DONE.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i: latch way; latch paddr with [3:0] cleared; clear line buffer, counter and err; next state SEND.
  - kill_i in IDLE is ignored.
- SEND:
  - mem_req_valid_o = 1, held until mem_req_ready_i.
  - mem_req_ready_i with no kill: go to COLLECT.
  - kill_i with no ready: go to IDLE; no memory traffic.
  - kill_i and mem_req_ready_i in the same cycle: the request is committed; go to DRAIN.
- COLLECT, per accepted beat (mem_resp_valid_i):
  - Write line[beat*32 +: 32] using mem_resp_beat_i.
  - If mem_resp_beat_i != counter, or mem_resp_err_i = 1: set err (sticky).
  - Increment counter.
  - On the 4th beat (counter == 3): go to DONE.
- DONE:
  - Lasts exactly one cycle; fill_valid_o = 1 in this cycle.
  - fill_xcpt_o = err; fill_data_o, fill_way_o and fill_paddr_o are stable and registered.
  - Next state IDLE; req_ready_o = 0 during DONE.
  - Total latency: fill_valid_o is asserted 1 cycle after the 4th beat is accepted.
- kill_i in COLLECT:
  - Go to DRAIN. A beat arriving in the same cycle is counted but not used.
  - If that beat is the 4th: go directly to IDLE, no fill pulse.
- DRAIN:
  - Consume and discard beats, counting to 4 total, then go to IDLE.
  - fill_valid_o is never asserted; kill_i is ignored.
- Other ignore rules:
  - kill_i in DONE is ignored; the pulse is still emitted and the icache discards it.
  - mem_resp_valid_i outside COLLECT/DRAIN is ignored.
- Backpressure:
  - req_valid_i while req_ready_o = 0 is not accepted; the requester holds it.
  - A new request is accepted no earlier than the cycle after DONE or DRAIN completes.
- Counter wrap: the 2-bit counter wraps 3 -> 0 only on the final beat; it is reset on every accept.
- Outputs: all outputs are registered or pure state decodes; no combinational path from kill_i or mem_* to fill_*.

Test Plan:
- Basic fill: req paddr=0x12345F, way=2; mem ready same cycle; beats 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles -> mem_req_addr_o=0x123450; fill_valid_o pulses 1 cycle after beat 3; fill_data_o=0x44444444_33333333_22222222_11111111; fill_way_o=2; fill_xcpt_o=0.
- Gapped beats plus back-to-back requests: 2 idle cycles between beats; second req_valid_i held during the fill -> second request accepted in the cycle after DONE; line assembled correctly; no overlap.
- Kill timing:
  - kill_i in SEND with mem_req_ready_i=0 -> back to IDLE; mem_req_valid_o drops; no beats expected.
  - kill_i together with mem_req_ready_i -> DRAIN consumes 4 beats; no fill_valid_o; busy_o falls after beat 3.
- Kill after 2 beats -> remaining 2 beats drained; fill_valid_o never asserted; next request fills cleanly with fresh data (no stale bytes).
- Errors:
  - mem_resp_err_i on beat 1 -> fill_valid_o=1 with fill_xcpt_o=1.
  - Out-of-order beat index (1 arrives first) -> fill_xcpt_o=1.
  - Next clean fill -> fill_xcpt_o=0.
- Reset mid-COLLECT after 1 beat -> all outputs at reset values next cycle; req_ready_o=1; no fill pulse; subsequent fill correct.
